// File: rtl/frame_mem_server_if.sv
// Request/response channel bundle for frame_mem_server: the master issues pixel
// requests and consumes responses; the slave serves them in order.
interface frame_mem_server_if #(
   parameter int unsigned WW = 16
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [WW-1:0] req_y;
   logic [WW-1:0] req_x;
   logic [1:0]    req_c;
   logic [7:0]    req_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [7:0]    rsp_data;
   logic          rsp_err;

   modport master (
      output req_valid, req_write, req_y, req_x, req_c, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_y, req_x, req_c, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/frame_mem_server.sv
// Pipelined pixel-addressed frame memory slave with credit flow control and an in-order
// response FIFO. Optional macro FRAME_MEM_BOUND_ZERO_EN: out-of-frame accesses report no error.
module frame_mem_server #(
   parameter int unsigned AW = 16,
   parameter int unsigned WW = 16,
   parameter int unsigned FD = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [AW-1:0]     cfg_base,
   input  logic [WW-1:0]     cfg_width,
   input  logic [WW-1:0]     cfg_height,
   frame_mem_server_if.slave bus,
   output logic              busy
);
   localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
   localparam int unsigned CW = PW + 2;

   logic          r_live;
   logic          r_s1_vld;
   logic          r_s1_wr;
   logic          r_s1_oor;
   logic          r_s1_err;
   logic [7:0]    r_s1_data;
   logic [AW-1:0] r_s1_addr;
   logic          r_s2_vld;
   logic          r_s2_rd;
   logic          r_s2_err;
   logic [7:0]    r_s2_rdata;
   logic [7:0]    r_mem [0:(2**AW)-1];
   logic [8:0]    r_fifo [0:FD-1];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;

   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_oor;
   logic          w_err;
   logic [AW-1:0] w_addr;
   logic [CW-1:0] w_used;
   logic [7:0]    w_s2_data;

   // Modulo-2**AW arithmetic yields the full-precision result truncated to AW bits.
   assign w_addr = (AW'(cfg_width) * AW'(bus.req_y) + AW'(bus.req_x)) * AW'(3)
                 + AW'(bus.req_c) + cfg_base;
   assign w_oor  = (bus.req_x >= cfg_width) || (bus.req_y >= cfg_height) || (bus.req_c == 2'd3);
`ifdef FRAME_MEM_BOUND_ZERO_EN
   assign w_err  = (bus.req_c == 2'd3);
`else
   assign w_err  = w_oor;
`endif

   assign w_used        = CW'(r_count) + CW'(r_s1_vld) + CW'(r_s2_vld);
   assign bus.req_ready = r_live && (w_used < CW'(FD));
   assign w_accept      = bus.req_valid && bus.req_ready;
   assign w_push        = r_s2_vld;
   assign w_pop         = bus.rsp_valid && bus.rsp_ready;
   assign w_s2_data     = r_s2_rd ? r_s2_rdata : 8'h00;

   assign bus.rsp_valid = (r_count != '0);
   assign bus.rsp_data  = bus.rsp_valid ? r_fifo[r_rptr][7:0] : 8'h00;
   assign bus.rsp_err   = bus.rsp_valid && r_fifo[r_rptr][8];
   assign busy          = r_s1_vld || r_s2_vld || (r_count != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_live    <= 1'b0;
         r_s1_vld  <= 1'b0;
         r_s1_wr   <= 1'b0;
         r_s1_oor  <= 1'b0;
         r_s1_err  <= 1'b0;
         r_s1_data <= 8'h00;
         r_s1_addr <= '0;
         r_s2_vld  <= 1'b0;
         r_s2_rd   <= 1'b0;
         r_s2_err  <= 1'b0;
      end else begin
         r_live   <= 1'b1;
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_wr   <= bus.req_write;
            r_s1_oor  <= w_oor;
            r_s1_err  <= w_err;
            r_s1_data <= bus.req_data;
            r_s1_addr <= w_addr;
         end
         r_s2_vld <= r_s1_vld;
         r_s2_rd  <= r_s1_vld && !r_s1_wr && !r_s1_oor;
         r_s2_err <= r_s1_err;
      end
   end

   // Frame RAM keeps its contents across reset; only the S1 valid gates commits.
   always_ff @(posedge clk) begin
      if (r_s1_vld && r_s1_wr && !r_s1_oor) begin
         r_mem[r_s1_addr] <= r_s1_data;
      end
      r_s2_rdata <= r_mem[r_s1_addr];
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= {r_s2_err, w_s2_data};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_mem_server.sv
// Self-checking bench for frame_mem_server: directed scenarios plus randomized traffic
// scored against an in-order reference model of the frame memory.
module tb_frame_mem_server;
   localparam int unsigned AW = 16;
   localparam int unsigned WW = 16;
   localparam int unsigned FD = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [AW-1:0] cfg_base = 16'h0100;
   logic [WW-1:0] cfg_width = 16'd4;
   logic [WW-1:0] cfg_height = 16'd2;
   logic          busy;
   int            n_checks = 0;
   int            n_fail = 0;
   logic [7:0]    ref_mem [int];
   logic [8:0]    exp_q [$];
   logic [8:0]    got_q [$];

   frame_mem_server_if #(.WW(WW)) bus ();

   frame_mem_server #(.AW(AW), .WW(WW), .FD(FD)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_base  (cfg_base),
      .cfg_width (cfg_width),
      .cfg_height(cfg_height),
      .bus       (bus),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_n && bus.rsp_valid && bus.rsp_ready) got_q.push_back({bus.rsp_err, bus.rsp_data});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout, required finish");
      $fatal(1, "watchdog");
   end

   // Reference: byte-addressed frame, requests applied in acceptance order.
   function automatic logic [8:0] model(input logic wr, input int y, input int x, input int c,
                                        input logic [7:0] d);
      bit         oor;
      bit         err;
      longint     addr;
      logic [7:0] rd;
      oor = (x >= int'(cfg_width)) || (y >= int'(cfg_height)) || (c == 3);
`ifdef FRAME_MEM_BOUND_ZERO_EN
      err = (c == 3);
`else
      err = oor;
`endif
      addr = (longint'(cfg_base) + (longint'(cfg_width) * y + x) * 3 + c) % 65536;
      rd = 8'h00;
      if (!oor) begin
         if (wr) ref_mem[int'(addr)] = d;
         else if (ref_mem.exists(int'(addr))) rd = ref_mem[int'(addr)];
      end
      return {err, rd};
   endfunction

   task automatic send(input logic wr, input int y, input int x, input int c, input logic [7:0] d);
      logic rdy;
      bit   done = 0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_y     = WW'(y);
      bus.req_x     = WW'(x);
      bus.req_c     = 2'(c);
      bus.req_data  = d;
      for (int i = 0; i < 50 && !done; i++) begin
         rdy = bus.req_ready;
         @(posedge clk);
         if (rdy) begin
            done = 1;
            exp_q.push_back(model(wr, y, x, c, d));
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL send_accept: actual not accepted, required accepted within 50 cycles");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: actual busy=%b, required 0 within 200 cycles", busy);
      end
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_y = '0;
      bus.req_x = '0;
      bus.req_c = '0;
      bus.req_data = '0;
      bus.rsp_ready = 1'b1;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks += 5;
      if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: actual %b required 0", bus.req_ready); end
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: actual %b required 0", bus.rsp_valid); end
      if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: actual %h required 00", bus.rsp_data); end
      if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: actual %b required 0", bus.rsp_err); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: actual %b required 0", busy); end
      reset_n = 1'b1;
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_pre_edge: actual %b required 0", bus.req_ready); end
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready_post_edge: actual %b required 1", bus.req_ready); end
   endtask

   task automatic test_write_read();
      send(1'b1, 1, 2, 1, 8'hA5);
      send(1'b0, 1, 2, 1, 8'h00);
      drain();
      n_checks += 4;
      if (got_q.size() != 2) begin n_fail++; $display("FAIL wr_rd_count: actual %0d required 2", got_q.size()); end
      if (got_q.size() > 0 && got_q[0] !== 9'h000) begin n_fail++; $display("FAIL wr_rsp: actual %h required 000", got_q[0]); end
      if (got_q.size() > 1 && got_q[1] !== 9'h0A5) begin n_fail++; $display("FAIL rd_rsp: actual %h required 0a5", got_q[1]); end
      if (u_dut.r_mem[16'h113] !== 8'hA5) begin n_fail++; $display("FAIL ram_113: actual %h required a5", u_dut.r_mem[16'h113]); end
      exp_q.delete();
      got_q.delete();
      // Fill the whole frame so later reads have known contents.
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++)
            for (int c = 0; c < 3; c++) send(1'b1, y, x, c, 8'($urandom));
      drain();
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fill_count: actual %0d required %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL fill_rsp[%0d]: actual %h required %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_latency();
      bus.rsp_ready = 1'b1;
      send(1'b0, 0, 1, 2, 8'h00);
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n: actual %b required 0", bus.rsp_valid); end
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n1: actual %b required 0", bus.rsp_valid); end
      @(negedge clk);
      n_checks += 2;
      if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_n2: actual %b required 1", bus.rsp_valid); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: actual %b required 1", busy); end
      @(negedge clk);
      n_checks += 3;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: actual %b required 0", busy); end
      if (got_q.size() != 1) begin n_fail++; $display("FAIL lat_count: actual %0d required 1", got_q.size()); end
      if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL lat_rsp: actual %h required %h", got_q[0], exp_q[0]); end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_credit();
      int   acc = 0;
      logic rdy;
      bus.rsp_ready = 1'b0;
      for (int phase = 0; phase < 2; phase++) begin
         if (phase == 1) bus.rsp_ready = 1'b1;
         for (int cyc = 0; cyc < ((phase == 0) ? 8 : 50) && acc < 6; cyc++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_y = WW'(acc / 4);
            bus.req_x = WW'(acc % 4);
            bus.req_c = 2'(acc % 3);
            rdy = bus.req_ready;
            @(posedge clk);
            if (rdy) begin
               exp_q.push_back(model(1'b0, acc / 4, acc % 4, acc % 3, 8'h00));
               acc++;
            end
            @(negedge clk);
         end
         if (phase == 0) begin
            n_checks += 3;
            if (acc != 4) begin n_fail++; $display("FAIL credit_accepted: actual %0d required 4", acc); end
            if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL credit_ready: actual %b required 0", bus.req_ready); end
            if (got_q.size() != 0) begin n_fail++; $display("FAIL credit_no_pop: actual %0d required 0", got_q.size()); end
         end
      end
      bus.req_valid = 1'b0;
      drain();
      n_checks += 2;
      if (acc != 6) begin n_fail++; $display("FAIL credit_total: actual %0d required 6", acc); end
      if (got_q.size() != 6) begin n_fail++; $display("FAIL credit_count: actual %0d required 6", got_q.size()); end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL credit_rsp[%0d]: actual %h required %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_range();
      bus.rsp_ready = 1'b1;
      send(1'b0, 0, 4, 0, 8'h00);
      send(1'b0, 2, 0, 0, 8'h00);
      send(1'b0, 0, 0, 3, 8'h00);
      send(1'b1, 0, 5, 0, 8'hEE);
      send(1'b0, 1, 1, 0, 8'h00);
      drain();
      n_checks++;
      if (got_q.size() != 5) begin n_fail++; $display("FAIL range_count: actual %0d required 5", got_q.size()); end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL range_rsp[%0d]: actual %h required %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      n_checks++;
      if (got_q.size() > 2 && got_q[2] !== 9'h100) begin n_fail++; $display("FAIL range_c3: actual %h required 100", got_q[2]); end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      bus.rsp_ready = 1'b1;
      send(1'b1, 0, 0, 0, 8'h3C);
      send(1'b0, 0, 0, 0, 8'h00);
      drain();
      n_checks += 2;
      if (got_q.size() != 2) begin n_fail++; $display("FAIL raw_count: actual %0d required 2", got_q.size()); end
      if (got_q.size() > 1 && got_q[1] !== 9'h03C) begin n_fail++; $display("FAIL raw_data: actual %h required 03c", got_q[1]); end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_random();
      int   acc = 0;
      bit   pend = 0;
      logic rdy;
      logic wr;
      int   y, x, c;
      logic [7:0] d;
      for (int cyc = 0; cyc < 4000 && acc < 300; cyc++) begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         if (!pend && $urandom_range(0, 4) != 0) begin
            wr = ($urandom_range(0, 2) == 0);
            y  = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            x  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            c  = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
            d  = 8'($urandom);
            pend = 1;
         end
         bus.req_valid = pend;
         bus.req_write = wr;
         bus.req_y = WW'(y);
         bus.req_x = WW'(x);
         bus.req_c = 2'(c);
         bus.req_data = d;
         rdy = bus.req_ready;
         @(posedge clk);
         if (pend && rdy) begin
            exp_q.push_back(model(wr, y, x, c, d));
            pend = 0;
            acc++;
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      drain();
      n_checks += 2;
      if (acc != 300) begin n_fail++; $display("FAIL rand_accepted: actual %0d required 300", acc); end
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: actual %0d required %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand_rsp[%0d]: actual %h required %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      bus.rsp_ready = 1'b1;
      send(1'b0, 0, 0, 1, 8'h00);
      send(1'b0, 0, 1, 1, 8'h00);
      send(1'b0, 0, 2, 1, 8'h00);
      n_checks++;
      if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: actual %b required 1", bus.rsp_valid); end
      reset_n = 1'b0;
      exp_q.delete();
      got_q.delete();
      #1;
      n_checks += 3;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: actual %b required 0", bus.rsp_valid); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: actual %b required 0", busy); end
      if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_req_ready: actual %b required 0", bus.req_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      n_checks += 2;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_stale: actual %0d required 0", got_q.size()); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: actual %b required 0", busy); end
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++)
            for (int c = 0; c < 3; c++) send(1'b0, y, x, c, 8'h00);
      drain();
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count: actual %0d required %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL mid_rsp[%0d]: actual %h required %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_latency();
      test_credit();
      test_range();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_mem_server.md
Name: frame_mem_server

Overview:
Synthesizable pixel-addressed frame memory responder. It serves (y, x, channel) read/write requests from filter engines and BMP loaders over a valid/ready request channel and returns in-order responses over a valid/ready response channel. Byte address = cfg_base + (cfg_width*y + x)*3 + c, with BGR channel order (0=B, 1=G, 2=R). It replaces the behavioural frame-memory calls with a real pipelined slave.

Parameters:
AW, 16, byte address width; internal RAM holds 2**AW bytes
WW, 16, coordinate / dimension width
FD, 4, response FIFO depth (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
cfg_base  input  AW  frame base byte address
cfg_width  input  WW  image width in pixels
cfg_height  input  WW  image height in pixels
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&&ready at a rising edge
req_write  input  1  1=write, 0=read
req_y  input  WW  pixel row
req_x  input  WW  pixel column
req_c  input  2  channel 0=B 1=G 2=R
req_data  input  8  write byte
rsp_valid  output  1  response valid (head of FIFO)
rsp_ready  input  1  response consumed when valid&&ready at a rising edge
rsp_data  output  8  read byte; 8'h00 for writes and errored reads
rsp_err  output  1  request was out of range
busy  output  1  any request in pipeline or FIFO

Behaviour:
- Reset (async assert, sync use after release): req_ready=0 during reset, then 1 on the first edge after release when credits are free; rsp_valid=0, rsp_data=0, rsp_err=0, busy=0; pipeline valids and FIFO pointers cleared. RAM contents are not reset.
- Reset asserted mid-operation: all in-flight requests and queued responses are discarded. A write already committed to RAM stays; a write still in stage S1 is dropped.
- Pipeline, in order, one request per cycle:
  - S1 at accept edge N: register op, data, computed address, and range check.
  - S2 at edge N+1: RAM access; write commits, or the synchronous read is registered.
  - Edge N+2: push response into FIFO.
  - With an empty FIFO, rsp_valid is high in the cycle after edge N+2 (3-cycle latency).
- Range check: err = (x >= cfg_width) || (y >= cfg_height) || (c == 3). An errored write does not touch RAM; an errored read returns 8'h00 with rsp_err=1.
- Address arithmetic: full-precision product cfg_width*y (2*WW bits) plus x, times 3, plus c, plus cfg_base, truncated modulo 2**AW. There is no error on wrap.
- Every request, read or write, yields exactly one response. Responses are returned in request order.
- Credit flow control: req_ready = (fifo_count + inflight) < FD, where inflight counts valid S1/S2 entries. With rsp_ready held 0, exactly FD requests are accepted and then req_ready=0. The FIFO never overflows.
- FIFO pop and push in the same cycle keep count unchanged. Pop on an empty FIFO is impossible because rsp_valid=0.
- Read-after-write to the same address on consecutive cycles returns the new data (the write commits in S2 one edge before the read's S2).
- cfg_* are sampled in S1 and must be stable while busy=1; changes while busy are undefined.
- busy = S1 valid | S2 valid | fifo_count != 0.

Optional Feature:
FRAME_MEM_BOUND_ZERO_EN
- Defined: out-of-range reads return 8'h00 with rsp_err=0, matching the zero-boundary convention of the filter engines. Out-of-range writes are still dropped silently with rsp_err=0. c==3 still reports rsp_err=1.
- Undefined: behaviour exactly as in Behaviour.

Test Plan:
1. Reset, cfg_base=0x100, width=4, height=2. Write (y=1, x=2, c=1, 0xA5), then read it -> write response err=0 data=0; read response data=0xA5 err=0; RAM byte 0x100+(4+2)*3+1=0x113 equals 0xA5.
2. Single read with rsp_ready=1 and empty FIFO, accepted at edge N -> rsp_valid first high after edge N+2; busy falls one cycle after the pop.
3. rsp_ready=0, issue 6 back-to-back reads -> exactly 4 accepted, req_ready=0. Raise rsp_ready -> 6 responses in order, no loss or duplication.
4. Read x=4 (width=4), then y=2, then c=3 -> three responses with data=0x00 err=1. With FRAME_MEM_BOUND_ZERO_EN, the first two have err=0 and the third err=1. An out-of-range write leaves RAM unchanged.
5. Write 0x3C to (0,0,0) followed next cycle by read (0,0,0) -> read returns 0x3C.
6. Stream 3 reads, assert reset_n=0 for one cycle mid-stream -> rsp_valid=0 and busy=0 immediately. After release no stale responses appear and previously committed RAM data reads back intact.
